synfull_inject_sched: RTL and testbench

SYNFULL_INJECT_SCHED -- requirements
Module: synfull_inject_sched

---
 rtl/synfull_inject_sched.sv | 193 +++++++++++++++++++
 tb/tb_synfull_inject_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synfull_inject_sched.sv
`default_nettype none
// ============================================================================
// Module      : synfull_inject_sched
// Description : Per-endpoint request injection scheduler for a trace-driven
//               NoC. Zero-latency bypass when a FIFO is empty, per-endpoint
//               deferral FIFOs under backpressure, drop/outstanding counters,
//               and an IDLE/RUN/DRAIN/DONE session FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module synfull_inject_sched #(
  parameter int NE    = 16,
  parameter int DEPTH = 4,
  parameter int DW    = 64,
  parameter int OW    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             trace_done_i,
  input  logic [NE-1:0]    new_valid_i,
  input  logic [NE*DW-1:0] new_data_i,
  input  logic [NE-1:0]    ne_ready_i,
  input  logic [NE-1:0]    del_valid_i,
  output logic [NE-1:0]    inj_valid_o,
  output logic [NE*DW-1:0] inj_data_o,
  output logic             stall_o,
  output logic             end_o,
  output logic [OW-1:0]    drop_cnt_o,
  output logic [OW-1:0]    outstanding_o,
  output logic             err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NE + 1);
  localparam int SW = OW + CW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [OW-1:0] out_q, out_d;
  logic          err_q, err_d;

  logic          sess_start;
  logic [NE-1:0] accept, empty, inject, drop, near_full;
  logic [CW-1:0] inj_cnt, del_cnt, drop_n;
  logic [SW-1:0] sum, diff;

  function automatic logic [CW-1:0] popcnt(input logic [NE-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NE; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // A new session begins only from IDLE or DONE; RUN/DRAIN ignore start_i.
  assign sess_start = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Per-endpoint deferral FIFO with combinational bypass when empty.
  for (genvar k = 0; k < NE; k++) begin : g_ep
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] new_data;
    logic          full, pop, push_req, push_ok;

    assign new_data       = new_data_i[k*DW +: DW];
    assign empty[k]       = (cnt_q == '0);
    assign full           = (cnt_q == (AW+1)'(DEPTH));
    assign near_full[k]   = (cnt_q >= (AW+1)'(DEPTH - 1));
    assign accept[k]      = new_valid_i[k] && (state_q == ST_RUN);
    assign inj_valid_o[k] = !empty[k] || accept[k];
    assign inj_data_o[k*DW +: DW] = empty[k] ? new_data : mem_q[rd_q];
    assign inject[k]      = inj_valid_o[k] && ne_ready_i[k];
    // Head leaves on injection; a bypassed request that was not taken, or
    // any request arriving behind a non-empty FIFO, must be stored.
    assign pop            = !empty[k] && ne_ready_i[k];
    assign push_req       = accept[k] && !(empty[k] && ne_ready_i[k]);
    assign push_ok        = push_req && (!full || pop);
    assign drop[k]        = push_req && full && !pop;

    // Next-state of the FIFO pointers, occupancy and storage.
    always_comb begin
      mem_d = mem_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (push_ok) begin
        mem_d[wr_q] = new_data;
        wr_d        = wr_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      if (sess_start) begin
        rd_d  = '0;
        wr_d  = '0;
        cnt_d = '0;
      end
    end

    // FIFO control registers; reset discards any held entries.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        cnt_q <= cnt_d;
      end
    end

    // Payload storage carries no reset; validity comes from cnt_q.
    always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
    end
  end

  assign inj_cnt = popcnt(inject);
  assign del_cnt = popcnt(del_valid_i);
  assign drop_n  = popcnt(drop);

  // Session FSM plus saturating drop/outstanding counters and sticky error.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    out_d   = out_q;
    err_d   = err_q;
    sum     = SW'(out_q) + SW'(inj_cnt);
    diff    = '0;

    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN:   if (trace_done_i) state_d = ST_DRAIN;
      ST_DRAIN: if ((&empty) && (out_q == '0)) state_d = ST_DONE;
      ST_DONE:  if (start_i) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    if (sum < SW'(del_cnt)) begin
      out_d = '0;
      err_d = 1'b1;
    end else begin
      diff = sum - SW'(del_cnt);
      out_d = (diff > SW'({OW{1'b1}})) ? {OW{1'b1}} : diff[OW-1:0];
    end

    if ((SW'(drop_q) + SW'(drop_n)) > SW'({OW{1'b1}})) drop_d = {OW{1'b1}};
    else drop_d = drop_q + OW'(drop_n);

    if ((|new_valid_i) && (state_q != ST_RUN)) err_d = 1'b1;

    if (sess_start) begin
      drop_d = '0;
      out_d  = '0;
      err_d  = 1'b0;
    end
  end

  // Session state and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      drop_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign stall_o       = (state_q != ST_RUN) || (|near_full);
  assign end_o         = (state_q == ST_DONE);
  assign drop_cnt_o    = drop_q;
  assign outstanding_o = out_q;
  assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_synfull_inject_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_synfull_inject_sched
// Description : Self-checking bench for synfull_inject_sched: directed vector
//               table, hand-written corner sequences, and randomized traffic
//               checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synfull_inject_sched;

  localparam int NE    = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int OW    = 8;
  localparam int OMAX  = (1 << OW) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             trace_done_i = 1'b0;
  logic [NE-1:0]    new_valid_i = '0;
  logic [NE*DW-1:0] new_data_i = '0;
  logic [NE-1:0]    ne_ready_i = '0;
  logic [NE-1:0]    del_valid_i = '0;
  logic [NE-1:0]    inj_valid_o;
  logic [NE*DW-1:0] inj_data_o;
  logic             stall_o;
  logic             end_o;
  logic [OW-1:0]    drop_cnt_o;
  logic [OW-1:0]    outstanding_o;
  logic             err_o;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  // Reference model state
  int            m_state;
  logic [DW-1:0] mq [NE][$];
  int            m_out, m_drop;
  bit            m_err;

  synfull_inject_sched #(.NE(NE), .DEPTH(DEPTH), .DW(DW), .OW(OW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .trace_done_i(trace_done_i),
    .new_valid_i(new_valid_i), .new_data_i(new_data_i), .ne_ready_i(ne_ready_i),
    .del_valid_i(del_valid_i), .inj_valid_o(inj_valid_o), .inj_data_o(inj_data_o),
    .stall_o(stall_o), .end_o(end_o), .drop_cnt_o(drop_cnt_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NE; k++) mq[k].delete();
    m_out = 0;
    m_drop = 0;
    m_err = 0;
  endtask

  // Compare every DUT output with what the model says this cycle shows.
  task automatic compare_model();
    logic [NE-1:0] ev;
    bit st;
    if (!cmp_en) return;
    st = (m_state != M_RUN);
    for (int k = 0; k < NE; k++) begin
      bit had;
      logic [DW-1:0] ed;
      had = (mq[k].size() != 0);
      ev[k] = had || (new_valid_i[k] && m_state == M_RUN);
      ed = had ? mq[k][0] : new_data_i[k*DW +: DW];
      if (mq[k].size() >= DEPTH - 1) st = 1;
      if (ev[k]) chk($sformatf("model_data[%0d]", k), 64'(inj_data_o[k*DW +: DW]), 64'(ed));
    end
    chk("model_valid", 64'(inj_valid_o), 64'(ev));
    chk("model_stall", 64'(stall_o), 64'(st));
    chk("model_end", 64'(end_o), 64'(m_state == M_DONE));
    chk("model_drop", 64'(drop_cnt_o), 64'(m_drop));
    chk("model_out", 64'(outstanding_o), 64'(m_out));
    chk("model_err", 64'(err_o), 64'(m_err));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int inj, drops, nout;
    bit was_empty, sess;
    inj = 0;
    drops = 0;
    was_empty = 1;
    for (int k = 0; k < NE; k++) if (mq[k].size() != 0) was_empty = 0;
    sess = start_i && (m_state == M_IDLE || m_state == M_DONE);
    for (int k = 0; k < NE; k++) begin
      bit acc, had;
      acc = new_valid_i[k] && (m_state == M_RUN);
      had = (mq[k].size() != 0);
      if ((had || acc) && ne_ready_i[k]) inj++;
      if (had && ne_ready_i[k]) void'(mq[k].pop_front());
      if (acc && (had || !ne_ready_i[k])) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(new_data_i[k*DW +: DW]);
        else drops++;
      end
    end
    nout = m_out + inj - $countones(del_valid_i);
    if (nout < 0) begin nout = 0; m_err = 1; end
    if (nout > OMAX) nout = OMAX;
    if (new_valid_i != 0 && m_state != M_RUN) m_err = 1;
    m_drop = (m_drop + drops > OMAX) ? OMAX : m_drop + drops;
    case (m_state)
      M_IDLE:  if (start_i) m_state = M_RUN;
      M_RUN:   if (trace_done_i) m_state = M_DRAIN;
      M_DRAIN: if (was_empty && m_out == 0) m_state = M_DONE;
      default: if (start_i) m_state = M_RUN;
    endcase
    m_out = nout;
    if (sess) model_clear();
    if (rst_i) begin
      m_state = M_IDLE;
      model_clear();
    end
  endtask

  // Inputs are applied at posedge+1; outputs sampled at posedge+3.
  task automatic settle();
    #2;
    compare_model();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    rst_i = 0; start_i = 0; trace_done_i = 0;
    new_valid_i = '0; new_data_i = '0; ne_ready_i = '0; del_valid_i = '0;
  endtask

  typedef struct {
    bit            rst, start, tdone;
    logic [NE-1:0] nv, rdy, del;
    logic [DW-1:0] nd;
    logic [NE-1:0] e_valid;
    logic [DW-1:0] e_d0;
    bit            e_stall, e_end, e_err;
    int            e_out, e_drop;
  } vec_t;

  function automatic vec_t mk(bit rs, bit st, bit td, logic [NE-1:0] nv, logic [NE-1:0] rdy,
                              logic [NE-1:0] del, logic [DW-1:0] nd, logic [NE-1:0] ev,
                              logic [DW-1:0] ed, bit es, bit ee, bit er, int eo, int edr);
    vec_t v;
    v.rst = rs; v.start = st; v.tdone = td; v.nv = nv; v.rdy = rdy; v.del = del; v.nd = nd;
    v.e_valid = ev; v.e_d0 = ed; v.e_stall = es; v.e_end = ee; v.e_err = er;
    v.e_out = eo; v.e_drop = edr;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    // rst st td nv rdy del nd | valid d0 stall end err out drop
    tbl[0]  = mk(0,1'b0,0,4'h0,4'h0,4'h0,16'h0000, 4'h0,16'h00A5*0,1,0,0,0,0);
    tbl[1]  = mk(0,1'b1,0,4'h0,4'h0,4'h0,16'h0000, 4'h0,16'h0000,1,0,0,0,0);
    tbl[2]  = mk(0,1'b0,0,4'h1,4'h1,4'h0,16'h00A5, 4'h1,16'h00A5,0,0,0,0,0);
    tbl[3]  = mk(0,1'b0,0,4'h0,4'h0,4'h0,16'h0000, 4'h0,16'h0000,0,0,0,1,0);
    tbl[4]  = mk(0,1'b0,0,4'h0,4'h0,4'h1,16'h0000, 4'h0,16'h0000,0,0,0,1,0);
    tbl[5]  = mk(0,1'b0,0,4'h0,4'h0,4'h1,16'h0000, 4'h0,16'h0000,0,0,0,0,0);
    tbl[6]  = mk(0,1'b0,0,4'h0,4'h0,4'h0,16'h0000, 4'h0,16'h0000,0,0,1,0,0);
    tbl[7]  = mk(0,1'b0,0,4'h2,4'h0,4'h0,16'h1234, 4'h2,16'h0000,0,0,1,0,0);
    tbl[8]  = mk(0,1'b0,0,4'h2,4'h0,4'h0,16'h5678, 4'h2,16'h0000,0,0,1,0,0);
    tbl[9]  = mk(0,1'b0,0,4'h2,4'h0,4'h0,16'h9ABC, 4'h2,16'h0000,0,0,1,0,0);
    tbl[10] = mk(0,1'b0,0,4'h0,4'h0,4'h0,16'h0000, 4'h2,16'h0000,1,0,1,0,0);
    tbl[11] = mk(0,1'b0,1,4'h0,4'h2,4'h0,16'h0000, 4'h2,16'h0000,1,0,1,0,0);
    tbl[12] = mk(0,1'b0,0,4'h0,4'h2,4'h0,16'h0000, 4'h2,16'h0000,1,0,1,1,0);
    tbl[13] = mk(0,1'b0,0,4'h1,4'hF,4'h0,16'hFFFF, 4'h2,16'h0000,1,0,1,2,0);
    tbl[14] = mk(0,1'b0,0,4'h0,4'h0,4'h7,16'h0000, 4'h0,16'h0000,1,0,1,3,0);
    tbl[15] = mk(0,1'b0,0,4'h0,4'h0,4'h0,16'h0000, 4'h0,16'h0000,1,0,1,0,0);
    tbl[16] = mk(0,1'b0,0,4'h0,4'h0,4'h0,16'h0000, 4'h0,16'h0000,1,1,1,0,0);
    tbl[17] = mk(0,1'b1,0,4'h0,4'h0,4'h0,16'h0000, 4'h0,16'h0000,1,1,1,0,0);
    tbl[18] = mk(0,1'b0,0,4'h0,4'h0,4'h0,16'h0000, 4'h0,16'h0000,0,0,0,0,0);

    // Power-up reset: DUT state is unknown until the first reset edge.
    m_state = M_IDLE;
    model_clear();
    idle_inputs();
    rst_i = 1;
    @(posedge clk_i); #1;
    advance();
    rst_i = 0;
    cmp_en = 1;

    // Directed vector table: reset state, bypass, underflow, backpressure,
    // DRAIN rejection, completion and restart.
    for (int i = 0; i < 19; i++) begin
      rst_i = tbl[i].rst; start_i = tbl[i].start; trace_done_i = tbl[i].tdone;
      new_valid_i = tbl[i].nv; new_data_i = {NE{tbl[i].nd}};
      ne_ready_i = tbl[i].rdy; del_valid_i = tbl[i].del;
      settle();
      chk($sformatf("tbl%0d_valid", i), 64'(inj_valid_o), 64'(tbl[i].e_valid));
      if (tbl[i].e_valid[0]) chk($sformatf("tbl%0d_d0", i), 64'(inj_data_o[DW-1:0]), 64'(tbl[i].e_d0));
      chk($sformatf("tbl%0d_stall", i), 64'(stall_o), 64'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_end", i), 64'(end_o), 64'(tbl[i].e_end));
      chk($sformatf("tbl%0d_err", i), 64'(err_o), 64'(tbl[i].e_err));
      chk($sformatf("tbl%0d_out", i), 64'(outstanding_o), 64'(tbl[i].e_out));
      chk($sformatf("tbl%0d_drop", i), 64'(drop_cnt_o), 64'(tbl[i].e_drop));
      advance();
    end
    idle_inputs();

    // Ordering under backpressure on endpoint 3.
    for (int id = 1; id <= 3; id++) begin
      new_valid_i = 4'h8; new_data_i = {NE{16'(id)}}; ne_ready_i = '0;
      settle(); advance();
    end
    idle_inputs();
    settle();
    chk("ord_stall_full", 64'(stall_o), 64'd1);
    advance();
    for (int id = 1; id <= 3; id++) begin
      ne_ready_i = 4'h8;
      settle();
      chk($sformatf("ord_data_%0d", id), 64'(inj_data_o[3*DW +: DW]), 64'(id));
      advance();
    end
    idle_inputs();
    settle();
    chk("ord_stall_clear", 64'(stall_o), 64'd0);
    chk("ord_out", 64'(outstanding_o), 64'd3);
    advance();
    for (int i = 0; i < 3; i++) begin
      del_valid_i = 4'h8; settle(); advance();
    end
    idle_inputs();

    // Overflow on endpoint 2, then push+pop while full.
    for (int i = 0; i < 6; i++) begin
      new_valid_i = 4'h4; new_data_i = {NE{16'h20 + 16'(i)}}; ne_ready_i = '0;
      settle(); advance();
    end
    idle_inputs();
    settle();
    chk("ovf_drop", 64'(drop_cnt_o), 64'd2);
    advance();
    new_valid_i = 4'h4; new_data_i = {NE{16'h0030}}; ne_ready_i = 4'h4;
    settle(); advance();
    idle_inputs();
    settle();
    chk("ovf_pushpop_drop", 64'(drop_cnt_o), 64'd2);
    advance();
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] exp_d;
      exp_d = (i < 3) ? 16'h21 + 16'(i) : 16'h30;
      ne_ready_i = 4'h4;
      settle();
      chk($sformatf("ovf_order_%0d", i), 64'(inj_data_o[2*DW +: DW]), 64'(exp_d));
      advance();
    end
    idle_inputs();

    // Completion: 5 injected above, trace done, then 5 deliveries.
    trace_done_i = 1; settle(); advance();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      del_valid_i = 4'h4; settle(); advance();
    end
    idle_inputs();
    settle();
    chk("cmp_out_zero", 64'(outstanding_o), 64'd0);
    chk("cmp_end_lag", 64'(end_o), 64'd0);
    advance();
    settle();
    chk("cmp_end", 64'(end_o), 64'd1);
    advance();

    // Reset mid-run with three entries held.
    start_i = 1; settle(); advance();
    idle_inputs();
    new_valid_i = 4'h2; new_data_i = {NE{16'h0077}}; ne_ready_i = 4'h2;
    settle(); advance();
    for (int i = 0; i < 3; i++) begin
      new_valid_i = 4'h1; new_data_i = {NE{16'h40 + 16'(i)}}; ne_ready_i = '0;
      settle(); advance();
    end
    idle_inputs();
    rst_i = 1; settle(); advance();
    rst_i = 0;
    settle();
    chk("rst_valid", 64'(inj_valid_o), 64'd0);
    chk("rst_out", 64'(outstanding_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd1);
    chk("rst_end", 64'(end_o), 64'd0);
    advance();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst_i        = ($urandom_range(0, 499) == 0);
      start_i      = ($urandom_range(0, 29) == 0);
      trace_done_i = ($urandom_range(0, 39) == 0);
      new_valid_i  = NE'($urandom);
      new_data_i   = {$urandom, $urandom};
      ne_ready_i   = NE'($urandom) | NE'($urandom);
      del_valid_i  = NE'($urandom) & NE'($urandom);
      settle();
      advance();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
